// File: rtl/ram8_16bit_pkg.sv
// ram8_16bit_pkg: shared Hack word constants for the RAM8 stage and its registers
package ram8_16bit_pkg;

    localparam int HACK_WORD_W = 16;
    localparam int RAM8_ADDR_W = 3;
    localparam int RAM8_DEPTH = 1 << RAM8_ADDR_W;
    localparam logic [HACK_WORD_W-1:0] HACK_WORD_RST = 16'h0000;

endpackage

// File: rtl/ram8_16bit_register.sv
// register_16bit: 16-bit load-enabled register with async active-low clear
module register_16bit
    import ram8_16bit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [HACK_WORD_W-1:0] in,
    input  logic                   load,
    output logic [HACK_WORD_W-1:0] out
);

    logic [HACK_WORD_W-1:0] data_d;
    logic [HACK_WORD_W-1:0] data_q;

    // Per-bit 2:1 mux: capture new data on load, otherwise recirculate
    always_comb begin
        data_d = load ? in : data_q;
    end

    // Bit cells: D flip-flops cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= HACK_WORD_RST;
        else        data_q <= data_d;
    end

    assign out = data_q;

endmodule

// File: rtl/ram8_16bit.sv
// ram8_16bit: 8 x 16-bit memory, demuxed load fan-out and combinational mux read
module ram8_16bit
    import ram8_16bit_pkg::*;
#(
    parameter int WIDTH = HACK_WORD_W,
    parameter int DEPTH = RAM8_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out
);

    logic [DEPTH-1:0] load_k;
    logic [WIDTH-1:0] word [DEPTH];

    // 8-way demux: at most one register sees load, the one addressed
    always_comb begin
        load_k = '0;
        load_k[address] = load;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        register_16bit u_reg (
            .clk  (clk),
            .rst_n(rst_n),
            .in   (in),
            .load (load_k[k]),
            .out  (word[k])
        );
    end

    // 16-bit 8-way mux: zero-latency read of the addressed word, no bypass of in
    always_comb begin
        out = word[address];
    end

endmodule

// File: tb/tb_ram8_16bit.sv
// tb_ram8_16bit: directed self-checking bench for ram8_16bit
`timescale 1ns/100ps
module tb_ram8_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        load = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [15:0] out;

    int n_cmp = 0;
    int n_err = 0;

    ram8_16bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .load   (load),
        .address(address),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        in = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        load = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            n_cmp++;
            if (out !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_sweep addr=%0d got=%h want=0000", a, out);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [15:0] exp;
        for (int k = 0; k < 8; k++) write_word(3'(k), 16'(16'h1111 * k + 16'h0F00));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            address = 3'(k);
            exp = 16'(16'h1111 * k + 16'h0F00);
            #1;
            n_cmp++;
            if (out !== exp) begin
                n_err++;
                $display("FAIL write_read addr=%0d got=%h want=%h", k, out, exp);
            end
        end
    endtask

    task automatic test_reset_after_writes();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #0.4;
            n_cmp++;
            if (out !== 16'h0000) begin
                n_err++;
                $display("FAIL async_clear addr=%0d got=%h want=0000 t=%0t", a, out, $time);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_during_write();
        write_word(3'd3, 16'hAAAA);
        @(negedge clk);
        address = 3'd3;
        in = 16'h5555;
        load = 1'b1;
        #1;
        n_cmp++;
        if (out !== 16'hAAAA) begin
            n_err++;
            $display("FAIL rdw_before got=%h want=AAAA", out);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out !== 16'h5555) begin
            n_err++;
            $display("FAIL rdw_after got=%h want=5555", out);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_hold();
        pulse_reset();
        address = 3'd6;
        in = 16'hFFFF;
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out !== 16'h0000) begin
                n_err++;
                $display("FAIL hold edge=%0d got=%h want=0000", i, out);
            end
        end
    endtask

    task automatic test_async_reset_mid_write();
        write_word(3'd7, 16'hBEEF);
        @(negedge clk);
        address = 3'd7;
        in = 16'h1234;
        load = 1'b1;
        #1;
        n_cmp++;
        if (out !== 16'hBEEF) begin
            n_err++;
            $display("FAIL mid_reset_pre got=%h want=BEEF", out);
        end
        #1;
        rst_n = 1'b0;
        #0.5;
        n_cmp++;
        if (out !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset_drop got=%h want=0000", out);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out !== 16'h0000) begin
                n_err++;
                $display("FAIL mid_reset_held edge=%0d got=%h want=0000", i, out);
            end
        end
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (out !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset_release got=%h want=0000", out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [8];
        pulse_reset();
        @(negedge clk);
        address = 3'd2;
        in = 16'h0001;
        load = 1'b1;
        @(negedge clk);
        in = 16'h0002;
        @(negedge clk);
        address = 3'd5;
        in = 16'h8000;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 8; k++) exp[k] = 16'h0000;
        exp[2] = 16'h0002;
        exp[5] = 16'h8000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            address = 3'(k);
            #1;
            n_cmp++;
            if (out !== exp[k]) begin
                n_err++;
                $display("FAIL back_to_back addr=%0d got=%h want=%h", k, out, exp[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_after_writes();
        test_read_during_write();
        test_hold();
        test_async_reset_mid_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
